// File: rtl/monpro_ctrl.sv
// Word-serial Montgomery product sequencer (CIOS schedule).
// Computes result = a*b*R^-1 mod n, where R = 2^(DATA_WIDTH*NUM_WORDS).
// A single mul_add word unit is issued one operation per cycle. Loop
// counters, the carry word, the scratch words t[] and the final
// conditional subtraction all live here.

// Word multiply-accumulate: {o_c, o_s} = i_x*i_y + i_z + i_c.
// The full 2W-bit sum cannot overflow: (2^W-1)^2 + 2(2^W-1) = 2^2W - 1.
module mul_add #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_y,
    input  logic [DATA_WIDTH-1:0] i_z,
    input  logic [DATA_WIDTH-1:0] i_c,
    output logic [DATA_WIDTH-1:0] o_s,
    output logic [DATA_WIDTH-1:0] o_c
);
    logic [2*DATA_WIDTH-1:0] w_sum;

    assign w_sum = {{DATA_WIDTH{1'b0}}, i_x} * {{DATA_WIDTH{1'b0}}, i_y}
                 + {{DATA_WIDTH{1'b0}}, i_z} + {{DATA_WIDTH{1'b0}}, i_c};
    assign o_s   = w_sum[DATA_WIDTH-1:0];
    assign o_c   = w_sum[2*DATA_WIDTH-1:DATA_WIDTH];
endmodule

module monpro_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] a,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] b,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] n,
    input  logic [DATA_WIDTH-1:0]           n0_inv,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH*NUM_WORDS-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int JW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_MUL, S_ADDC, S_MQ, S_RED0, S_RED, S_SHIFT, S_SUB, S_DONE
    } state_t;

    state_t r_state, r_next;
    logic [JW-1:0] r_i, r_j;

    // Latched operands; the live inputs are free to change after start.
    logic [NUM_WORDS-1:0][W-1:0] r_a, r_b, r_n;
    logic [W-1:0]                r_n0;

    // Scratch t[0..s-1] as an array; t[s] and t[s+1] kept separately
    // since they are only ever touched by the ADDC and SHIFT steps.
    logic [NUM_WORDS-1:0][W-1:0] r_t;
    logic [W-1:0]                r_ts, r_ts1;
    logic [W-1:0]                r_c, r_m;
    logic [NUM_WORDS-1:0][W-1:0] r_u, r_result;
    logic                        r_borrow;

    logic [W-1:0]  w_x, w_y, w_z, w_ci, w_lo, w_hi;
    logic          w_jlast, w_ilast, w_bin;
    logic [JW-1:0] w_jm1;
    logic [W:0]    w_diff;
    logic [NUM_WORDS-1:0][W-1:0] w_ufull;

    assign w_jlast = (r_j == JW'(NUM_WORDS - 1));
    assign w_ilast = (r_i == JW'(NUM_WORDS - 1));
    assign w_jm1   = r_j - JW'(1);

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    mul_add #(.DATA_WIDTH(W)) u_mul_add (
        .i_x (w_x),
        .i_y (w_y),
        .i_z (w_z),
        .i_c (w_ci),
        .o_s (w_lo),
        .o_c (w_hi)
    );

    // Operand routing into the word unit for the current schedule step.
    always_comb begin
        w_x  = '0;
        w_y  = '0;
        w_z  = '0;
        w_ci = '0;
        case (r_state)
            S_MUL: begin
                w_x  = r_a[r_j];
                w_y  = r_b[r_i];
                w_z  = r_t[r_j];
                w_ci = (r_j == '0) ? '0 : r_c;
            end
            S_ADDC, S_SHIFT: begin
                w_z  = r_ts;
                w_ci = r_c;
            end
            S_MQ: begin
                w_x = r_t[0];
                w_y = r_n0;
            end
            S_RED0: begin
                w_x = r_m;
                w_y = r_n[0];
                w_z = r_t[0];
            end
            S_RED: begin
                w_x  = r_m;
                w_y  = r_n[r_j];
                w_z  = r_t[r_j];
                w_ci = r_c;
            end
            default: ;
        endcase
    end

    // Word subtractor for the final t - n; bit W of the difference is the borrow out.
    always_comb begin
        w_bin   = (r_j == '0) ? 1'b0 : r_borrow;
        w_diff  = {1'b0, r_t[r_j]} - {1'b0, r_n[r_j]} - {{W{1'b0}}, w_bin};
        w_ufull = r_u;
        w_ufull[r_j] = w_diff[W-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= r_next;
    end

    // Next-state sequencing through the CIOS schedule.
    always_comb begin
        r_next = r_state;
        case (r_state)
            S_IDLE:  if (start) r_next = S_MUL;
            S_MUL:   if (w_jlast) r_next = S_ADDC;
            S_ADDC:  r_next = S_MQ;
            S_MQ:    r_next = S_RED0;
            S_RED0:  r_next = S_RED;
            S_RED:   if (w_jlast) r_next = S_SHIFT;
            S_SHIFT: r_next = w_ilast ? S_SUB : S_MUL;
            S_SUB:   if (w_jlast) r_next = S_DONE;
            S_DONE:  r_next = S_IDLE;
            default: r_next = S_IDLE;
        endcase
    end

    // Outer index i and inner index j; RED resumes at j=1 after RED0 consumed word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i <= '0;
            r_j <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_i <= '0;
                    r_j <= '0;
                end
                S_MUL, S_RED, S_SUB: r_j <= w_jlast ? '0 : r_j + JW'(1);
                S_RED0:  r_j <= JW'(1);
                S_SHIFT: begin
                    r_i <= w_ilast ? '0 : r_i + JW'(1);
                    r_j <= '0;
                end
                default: ;
            endcase
        end
    end

    // Scratch, carry and result updates; the result is chosen on the last SUB edge so it is valid while done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_t      <= '0;
            r_ts     <= '0;
            r_ts1    <= '0;
            r_c      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a   <= a;
                    r_b   <= b;
                    r_n   <= n;
                    r_n0  <= n0_inv;
                    r_t   <= '0;
                    r_ts  <= '0;
                    r_ts1 <= '0;
                    r_c   <= '0;
                end
                S_MUL: begin
                    r_t[r_j] <= w_lo;
                    r_c      <= w_hi;
                end
                S_ADDC: begin
                    r_ts  <= w_lo;
                    r_ts1 <= w_hi;
                    r_c   <= w_hi;
                end
                S_MQ:   r_m <= w_lo;
                S_RED0: r_c <= w_hi;
                S_RED: begin
                    r_t[w_jm1] <= w_lo;
                    r_c        <= w_hi;
                end
                S_SHIFT: begin
                    r_t[NUM_WORDS-1] <= w_lo;
                    r_ts             <= r_ts1 + w_hi;
                    r_ts1            <= '0;
                    r_c              <= w_hi;
                end
                S_SUB: begin
                    r_u[r_j] <= w_diff[W-1:0];
                    r_borrow <= w_diff[W];
                    if (w_jlast)
                        r_result <= ((r_ts != '0) || !w_diff[W]) ? w_ufull : r_t;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_monpro_ctrl.sv
// Self-checking bench for monpro_ctrl: a W=8/s=2 instance and a W=32/s=4
// instance, compared against a Montgomery reference computed by plain
// modular arithmetic (a*b mod n, then 2^-1 mod n applied once per bit of R).
module tb_monpro_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, busy8, done8;
    logic [15:0] a8, b8, n8, res8;
    logic [7:0]  inv8;

    logic         rst32, start32, busy32, done32;
    logic [127:0] a32, b32, n32, res32;
    logic [31:0]  inv32;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [127:0] N32 = {{31{4'hF}}, 4'h1} - 128'd16 - 128'd144 + 128'd16 + 128'd0;

    logic [15:0] dir_a [4] = '{16'h0001, 16'h8000, 16'hFFFE, 16'h0000};
    logic [15:0] dir_b [4] = '{16'h1234, 16'h0004, 16'hFFFE, 16'hABCD};
    logic [15:0] dir_e [4] = '{16'h1234, 16'h0002, 16'h0001, 16'h0000};

    monpro_ctrl #(.DATA_WIDTH(8), .NUM_WORDS(2)) u_dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8), .n(n8),
        .n0_inv(inv8), .busy(busy8), .done(done8), .result(res8)
    );

    monpro_ctrl #(.DATA_WIDTH(32), .NUM_WORDS(4)) u_dut32 (
        .clk(clk), .reset(rst32), .start(start32), .a(a32), .b(b32), .n(n32),
        .n0_inv(inv32), .busy(busy32), .done(done32), .result(res32)
    );

    // Reference: result r satisfies r*R == a*b (mod n), found by halving mod n.
    function automatic logic [127:0] mont_ref(input logic [127:0] fa, fb, fn, input int bits);
        logic [255:0] x;
        x = ({128'b0, fa} * {128'b0, fb}) % {128'b0, fn};
        for (int k = 0; k < bits; k++)
            x = x[0] ? ((x + {128'b0, fn}) >> 1) : (x >> 1);
        return x[127:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start in cycle 0; returns at the cycle-1 sampling point.
    task automatic launch(input bit wide, input logic [127:0] ta, tb, tn, input logic [31:0] ti);
        @(negedge clk);
        if (wide) begin
            a32 = ta; b32 = tb; n32 = tn; inv32 = ti; start32 = 1'b1;
        end else begin
            a8 = ta[15:0]; b8 = tb[15:0]; n8 = tn[15:0]; inv8 = ti[7:0]; start8 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        a8 = 16'($urandom); b8 = 16'($urandom); n8 = 16'($urandom); inv8 = 8'($urandom);
        a32 = {$urandom, $urandom, $urandom, $urandom};
        b32 = {$urandom, $urandom, $urandom, $urandom};
        n32 = {$urandom, $urandom, $urandom, $urandom};
        inv32 = $urandom;
        cyc = 1;
    endtask

    // Wait (bounded) for done; counts cycles where busy was not high on the way.
    task automatic wait_done(input bit wide, output int dcyc, output int busy_bad, output logic [127:0] res);
        dcyc = -1; busy_bad = 0; res = '0;
        while (dcyc < 0 && cyc < 120) begin
            if ((wide ? busy32 : busy8) !== 1'b1) busy_bad++;
            if ((wide ? done32 : done8) === 1'b1) begin
                dcyc = cyc;
                res  = wide ? res32 : {112'b0, res8};
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    // Reset in cycle at_cyc of a run just launched; no done may follow.
    task automatic abort_run(input bit wide, input int at_cyc);
        int nd = 0;
        for (int k = 1; k <= at_cyc; k++) begin
            if (k > 1) @(negedge clk);
            if ((wide ? done32 : done8) === 1'b1) nd++;
        end
        if (wide) rst32 = 1'b1; else rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0; rst32 = 1'b0;
        check("abort_busy",   wide ? busy32 : busy8, 0);
        check("abort_done",   wide ? done32 : done8, 0);
        check("abort_result", wide ? res32 : {112'b0, res8}, 0);
        repeat (60) begin
            @(negedge clk);
            if ((wide ? done32 : done8) === 1'b1) nd++;
        end
        check("abort_no_done", nd, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, bb, nd, d1, d2;
        logic [127:0] res, r1, r2, ra, rb;
        logic [31:0]  x, n0;

        rst8 = 1'b1; rst32 = 1'b1; start8 = 1'b0; start32 = 1'b0;
        a8 = '0; b8 = '0; n8 = '0; inv8 = '0;
        a32 = '0; b32 = '0; n32 = '0; inv32 = '0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst32 = 1'b0;
        check("reset_busy8",   busy8, 0);
        check("reset_done8",   done8, 0);
        check("reset_result8", res8, 0);
        check("reset_busy32",  busy32, 0);
        check("reset_result32", res32, 0);

        // Directed cases with n = 0xFFFF, where R == 1 mod n.
        for (int k = 0; k < 4; k++) begin
            launch(1'b0, {112'b0, dir_a[k]}, {112'b0, dir_b[k]}, 128'hFFFF, 32'h01);
            wait_done(1'b0, dcyc, bb, res);
            check("dir_done_cycle", dcyc, 17);
            check("dir_busy", bb, 0);
            check("dir_result", res, {112'b0, dir_e[k]});
            @(negedge clk);
            check("dir_busy_after", busy8, 0);
            check("dir_done_pulse", done8, 0);
        end

        // Random runs, n = 0xFFF1, started back-to-back one idle cycle apart.
        for (int k = 0; k < 1000; k++) begin
            ra = 128'($urandom_range(0, 32'hFFF0));
            rb = 128'($urandom_range(0, 32'hFFF0));
            launch(1'b0, ra, rb, 128'hFFF1, 32'hEF);
            wait_done(1'b0, dcyc, bb, res);
            check("rand_done_cycle", dcyc, 17);
            check("rand_result", res, mont_ref(ra, rb, 128'hFFF1, 16));
            check("rand_lt_n", res < 128'hFFF1, 1);
        end

        // Start pulses in cycles 5 and 17 ignored; cycle 18 accepted.
        launch(1'b0, 128'h1111, 128'h2222, 128'hFFF1, 32'hEF);
        nd = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            start8 = (k == 5) || (k == 17) || (k == 18);
            if (k == 18) begin
                a8 = 16'h0F0F; b8 = 16'h3C3C; n8 = 16'hFFF1; inv8 = 8'hEF;
            end
            if (done8 === 1'b1) begin
                nd++;
                if (nd == 1) begin d1 = k; r1 = {112'b0, res8}; end
                else begin d2 = k; r2 = {112'b0, res8}; end
            end
        end
        start8 = 1'b0;
        check("extra_start_done_count", nd, 2);
        check("extra_start_first_cycle", d1, 17);
        check("extra_start_first_result", r1, mont_ref(128'h1111, 128'h2222, 128'hFFF1, 16));
        check("extra_start_second_cycle", d2, 35);
        check("extra_start_second_result", r2, mont_ref(128'h0F0F, 128'h3C3C, 128'hFFF1, 16));

        // Abort an 8-bit run mid-flight, then a fresh run must still be correct.
        launch(1'b0, 128'h1357, 128'h2468, 128'hFFF1, 32'hEF);
        abort_run(1'b0, 10);
        launch(1'b0, 128'h1357, 128'h2468, 128'hFFF1, 32'hEF);
        wait_done(1'b0, dcyc, bb, res);
        check("post_abort8_cycle", dcyc, 17);
        check("post_abort8_result", res, mont_ref(128'h1357, 128'h2468, 128'hFFF1, 16));

        // W=32, s=4: n = 2^128 - 159, R mod n = 159; n0_inv by Newton iteration.
        n0 = N32[31:0];
        x  = n0;
        repeat (4) x = x * (32'd2 - n0 * x);
        launch(1'b1, 128'd1, 128'd159, N32, -x);
        wait_done(1'b1, dcyc, bb, res);
        check("w32_done_cycle", dcyc, 49);
        check("w32_busy", bb, 0);
        check("w32_result", res, 128'd1);
        for (int k = 0; k < 20; k++) begin
            ra = {$urandom & 32'h7FFFFFFF, $urandom, $urandom, $urandom};
            rb = {$urandom & 32'h7FFFFFFF, $urandom, $urandom, $urandom};
            launch(1'b1, ra, rb, N32, -x);
            wait_done(1'b1, dcyc, bb, res);
            check("w32_rand_cycle", dcyc, 49);
            check("w32_rand_result", res, mont_ref(ra, rb, N32, 128));
        end

        // Reset in cycle 20 of a 32-bit run.
        launch(1'b1, 128'd5, 128'd7, N32, -x);
        abort_run(1'b1, 20);
        launch(1'b1, 128'd5, 128'd7, N32, -x);
        wait_done(1'b1, dcyc, bb, res);
        check("post_abort32_cycle", dcyc, 49);
        check("post_abort32_result", res, mont_ref(128'd5, 128'd7, N32, 128));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
